wb_regfile: RTL

//  - Consumer end of the writeback interface: accepts the WB stage's data/IR_wb

---
 rtl/wb_regfile.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback consumer: 32x32 register file with HALT freeze and commit counter
// Optional write-before-read forwarding on both read ports when WB_BYPASS_EN is defined.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [31:0]      IR_wb,
  input  logic [DW-1:0]    data,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [DW-1:0]    rs1_data,
  output logic [DW-1:0]    rs2_data,
  output logic             wr_fire,
  output logic             halted,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  op;
  logic        dec_wr;
  logic [4:0]  dec_dest;
  logic        is_halt_op;
  logic        we;
  logic        unused_ir;
  logic [DW-1:0] regs [NREG];

  assign op         = IR_wb[31:26];
  assign is_halt_op = (op == 6'h3f);
  assign unused_ir  = ^{IR_wb[25:21], IR_wb[10:0]};

  // R-type writes rd; I-type ALU and loads write rt.
  always_comb begin
    dec_wr   = 1'b0;
    dec_dest = IR_wb[20:16];
    if (op[5:3] == 3'b000) begin
      dec_wr   = 1'b1;
      dec_dest = IR_wb[15:11];
    end else if (op[5:3] == 3'b001 || op[5:1] == 5'b11000) begin
      dec_wr   = 1'b1;
    end
  end

  assign we     = wb_valid & dec_wr & (state == S_RUN) & (dec_dest != 5'd0);
  assign halted = (state == S_HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (wb_valid && is_halt_op) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      wr_fire  <= 1'b0;
      wr_count <= '0;
    end else begin
      state   <= state_nxt;
      wr_fire <= we;
      if (we && wr_count != {CNT_W{1'b1}}) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[dec_dest] <= data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
`ifdef WB_BYPASS_EN
    if (we && rs1_addr == dec_dest) rs1_data = data;
    if (we && rs2_addr == dec_dest) rs2_data = data;
`else
`endif
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

endmodule
